sifive_datatap_sink: RTL and testbench
======================================

# sifive_datatap_sink

Receiving end of the core data-tap path. Samples the tapped retirement/CSR signals (a valid strobe, a 32-bit data word and four status flags) every cycle, buffers accepted samples in a small FIFO, and serializes each one as a multi-beat 16-bit record on a valid/ready trace stream toward the Insight trace funnel. Losses under back-pressure are counted and reported in-band, never silently.

## Interface
Parameters:
- DEPTH, 4: FIFO depth in records; power of two, ≥2.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  capture enable; low = taps ignored; drops not counted.
- tap_valid  input  1  tap sample strobe.
- tap_data  input  32  tapped data word.
- tap_flags  input  4  tapped single-bit status signals, bit 3..0.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  16  beat payload.
- out_last  output  1  final beat of the record.
- fifo_level  output  $clog2(DEPTH)+1  records held.

## Operation
- Capture: when enable && tap_valid at an edge, the record {flags, data, seq, ovf, drops} is pushed if the FIFO is not full, or is full with a pop in the same cycle. Otherwise the record is dropped.
- seq: 8-bit counter; increments per pushed record only; wraps 255→0.
- Drops: each drop increments drop_cnt, which saturates at 7, and sets ovf_pend.
  - The next pushed record carries ovf=1 and drops=drop_cnt; both are then cleared in that same cycle.
  - A drop coinciding with the push that clears them is counted fresh: drop_cnt=1, ovf_pend=1.
- Record beats, in order:
  - HDR = {flags[15:12], ovf[11], drops[10:8], seq[7:0]}.
  - DLO = data[15:0].
  - DHI = data[31:16].
  - TS (macro only).
- out_last is high on the final beat only.
- Serializer FSM states: IDLE, HDR, DLO, DHI, TS.
  - IDLE→HDR when the FIFO is non-empty.
  - Each state advances on out_valid && out_ready.
  - The final beat's handshake pops the FIFO and goes to HDR if more records remain, else to IDLE.
- enable falling mid-record does not abort emission; queued records still drain.
- Reset mid-record discards the FIFO contents and the partial record. No partial beat is emitted afterward.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, fifo_level=0. Internal: seq=0, drop_cnt=0, ovf_pend=0, FSM=IDLE, timestamp=0.
- Latency: a sample captured at edge N drives HDR with out_valid=1 after edge N+1, when the FIFO was empty and the FSM was IDLE.
- Back-to-back records: zero bubble. HDR of the next record follows the last-beat handshake of the previous one directly.
- Handshake: while out_valid && !out_ready, out_data and out_last hold stable. out_valid never deasserts without a handshake, except on reset.
- fifo_level reflects pushes and pops at the edge they occur. A simultaneous push and pop leaves it unchanged.
- Throughput: 3 beats per record (4 with the macro). Sustained tap rates above this fill the FIFO, and further samples are dropped.

## Configuration
- DATATAP_SINK_TIMESTAMP_EN:
  - Defined: a free-running 16-bit cycle counter (reset 0, wraps) is captured into each record at push. It is emitted as a fourth beat, TS, with out_last on TS.
  - Undefined: no counter and no TS beat; out_last is on DHI; FIFO width shrinks by 16.

## Structure
- Package sifive_datatap_pkg holds:
  - the record struct;
  - the beat-state enum;
  - header field bit positions;
  - DROP_MAX=7.
- Sub-module sifive_datatap_sink_fifo: synchronous FIFO of DEPTH × record width, with push, pop, full, empty and level outputs.
- Top level holds the capture/drop logic and the serializer FSM.

## Test plan
- Single sample: after reset, flags=4'b1010, data=32'hDEADBEEF, out_ready=1.
  - Beats 16'hA000, 16'hBEEF, 16'hDEAD, with out_last on the third beat.
  - HDR appears one cycle after capture.
- Back-pressure: hold out_ready=0 for 10 cycles mid-record. out_data stays stable, out_valid stays 1, and the beats resume unchanged.
- Overflow, DEPTH=4: out_ready=0 with 6 consecutive samples.
  - fifo_level=4 and 2 samples are dropped.
  - Release ready, then send one more sample. Its HDR has ovf=1, drops=2, seq=4.
- Drop saturation and seq wrap:
  - 20 drops give drops=7.
  - 256 accepted records make seq wrap, 8'hFF→8'h00.
- Simultaneous push/pop at full: a sample arriving on the last-beat handshake is accepted, no drop occurs, and fifo_level stays at 4.
- Reset mid-record, and the macro build:
  - Reset during DLO: out_valid=0 next cycle, fifo_level=0, seq restarts at 0.
  - With DATATAP_SINK_TIMESTAMP_EN defined: a 4th beat carries the capture cycle, and out_last is on TS.

Source files
------------

// File: rtl/sifive_datatap_pkg.sv
// Shared types for the data-tap sink: record layout, serializer states, header fields.
// Optional DATATAP_SINK_TIMESTAMP_EN adds a 16-bit capture timestamp to each record.
package sifive_datatap_pkg;

    localparam int unsigned DROP_MAX      = 7;
    localparam int unsigned HDR_SEQ_LSB   = 0;
    localparam int unsigned HDR_DROPS_LSB = 8;
    localparam int unsigned HDR_OVF_BIT   = 11;
    localparam int unsigned HDR_FLAGS_LSB = 12;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] data;
        logic [7:0]  seq;
        logic        ovf;
        logic [2:0]  drops;
`ifdef DATATAP_SINK_TIMESTAMP_EN
        logic [15:0] ts;
`endif
    } rec_t;

    localparam int unsigned REC_W = $bits(rec_t);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DLO,
        DHI,
        TS
    } beat_state_e;

    function automatic logic [15:0] make_hdr(input rec_t r);
        logic [15:0] h;
        h = '0;
        h[HDR_FLAGS_LSB +: 4] = r.flags;
        h[HDR_OVF_BIT]        = r.ovf;
        h[HDR_DROPS_LSB +: 3] = r.drops;
        h[HDR_SEQ_LSB +: 8]   = r.seq;
        return h;
    endfunction

endpackage

// File: rtl/sifive_datatap_sink_fifo.sv
// Synchronous record FIFO for the data-tap sink; push while full is accepted only with a pop.
// Record width follows DATATAP_SINK_TIMESTAMP_EN through the package struct.
module sifive_datatap_sink_fifo
    import sifive_datatap_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  rec_t                     wdata,
    output rec_t                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    rec_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/sifive_datatap_sink.sv
// Data-tap sink top: captures tap samples, accounts drops in-band, serializes 16-bit beats.
// DATATAP_SINK_TIMESTAMP_EN adds a free-running cycle stamp emitted as a fourth TS beat.
module sifive_datatap_sink
    import sifive_datatap_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     tap_valid,
    input  logic [31:0]              tap_data,
    input  logic [3:0]               tap_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
`ifdef DATATAP_SINK_TIMESTAMP_EN
    localparam beat_state_e LAST_ST = TS;
`else
    localparam beat_state_e LAST_ST = DHI;
`endif

    beat_state_e state;
    beat_state_e state_nxt;

    rec_t        new_rec;
    rec_t        head;
    logic        full;
    logic        empty;
    logic        beat_hs;
    logic        pop;
    logic        want;
    logic        push;
    logic        drop;
    logic        more;
    logic [7:0]  seq;
    logic [2:0]  drop_cnt;
    logic        ovf_pend;
`ifdef DATATAP_SINK_TIMESTAMP_EN
    logic [15:0] ts_cnt;
`endif

    assign beat_hs = (state != IDLE) && out_ready;
    assign pop     = beat_hs && (state == LAST_ST);
    assign want    = enable && tap_valid;
    assign push    = want && (!full || pop);
    assign drop    = want && !push;
    // A push landing on the final handshake keeps the next HDR bubble-free.
    assign more    = (fifo_level > LVL_W'(1)) || push;

    always_comb begin
        new_rec       = '0;
        new_rec.flags = tap_flags;
        new_rec.data  = tap_data;
        new_rec.seq   = seq;
        new_rec.ovf   = ovf_pend;
        new_rec.drops = drop_cnt;
`ifdef DATATAP_SINK_TIMESTAMP_EN
        new_rec.ts    = ts_cnt;
`endif
    end

    sifive_datatap_sink_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (new_rec),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            seq <= '0;
        end else if (push) begin
            seq <= seq + 8'd1;
        end
    end

    // Drop accounting is handed to the next pushed record, then restarts from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt <= '0;
            ovf_pend <= 1'b0;
        end else if (drop) begin
            if (push) begin
                drop_cnt <= 3'd1;
            end else if (drop_cnt != 3'(DROP_MAX)) begin
                drop_cnt <= drop_cnt + 3'd1;
            end
            ovf_pend <= 1'b1;
        end else if (push) begin
            drop_cnt <= '0;
            ovf_pend <= 1'b0;
        end
    end

`ifdef DATATAP_SINK_TIMESTAMP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = make_hdr(head);
                if (out_ready) begin
                    state_nxt = DLO;
                end
            end
            DLO: begin
                out_valid = 1'b1;
                out_data  = head.data[15:0];
                if (out_ready) begin
                    state_nxt = DHI;
                end
            end
            DHI: begin
                out_valid = 1'b1;
                out_data  = head.data[31:16];
`ifdef DATATAP_SINK_TIMESTAMP_EN
                if (out_ready) begin
                    state_nxt = TS;
                end
`else
                out_last = 1'b1;
                if (out_ready) begin
                    state_nxt = more ? HDR : IDLE;
                end
`endif
            end
            TS: begin
`ifdef DATATAP_SINK_TIMESTAMP_EN
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = head.ts;
                if (out_ready) begin
                    state_nxt = more ? HDR : IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sifive_datatap_sink.sv
// Scoreboard bench for sifive_datatap_sink; beat count follows DATATAP_SINK_TIMESTAMP_EN.
module tb_sifive_datatap_sink;

    localparam int unsigned DEPTH = 4;
`ifdef DATATAP_SINK_TIMESTAMP_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   enable = 1'b0;
    logic                   tap_valid = 1'b0;
    logic [31:0]            tap_data = '0;
    logic [3:0]             tap_flags = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [15:0]            out_data;
    logic                   out_last;
    logic [$clog2(DEPTH):0] fifo_level;

    beat_t       exp_q[$];
    int          mlevel;
    int          mdrop;
    int          mst;
    bit          movf;
    logic [7:0]  mseq;
    logic [15:0] mts;
    int          errors = 0;
    int          checks = 0;

    sifive_datatap_sink #(
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .tap_valid  (tap_valid),
        .tap_data   (tap_data),
        .tap_flags  (tap_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, score the beat accepted at the coming edge, advance the model.
    task automatic step(input bit en, input bit tv, input logic [31:0] d,
                        input logic [3:0] f, input bit rdy);
        bit          pop_e;
        bit          want;
        bit          push;
        int          lvl_pre;
        beat_t       b;
        logic [15:0] hdr;
        logic [2:0]  d3;
        enable    = en;
        tap_valid = tv;
        tap_data  = d;
        tap_flags = f;
        out_ready = rdy;
        pop_e     = 1'b0;
        lvl_pre   = mlevel;
        chk("out_valid", out_valid, 32'(mst != 0));
        if (mst != 0 && rdy) begin
            if (exp_q.size() == 0) begin
                chk("beat_avail", 32'(exp_q.size()), 1);
            end else begin
                b = exp_q.pop_front();
                chk("beat_data", out_data, b.d);
                chk("beat_last", out_last, b.l);
                pop_e = b.l;
            end
        end
        want = en && tv;
        push = want && ((mlevel < DEPTH) || pop_e);
        if (push) begin
            d3  = mdrop[2:0];
            hdr = {f, movf, d3, mseq};
            exp_q.push_back('{hdr, 1'b0});
            exp_q.push_back('{d[15:0], 1'b0});
            exp_q.push_back('{d[31:16], (NB == 3)});
`ifdef DATATAP_SINK_TIMESTAMP_EN
            exp_q.push_back('{mts, 1'b1});
`endif
            mseq++;
            mdrop  = 0;
            movf   = 1'b0;
            mlevel++;
        end else if (want) begin
            if (mdrop < 7) mdrop++;
            movf = 1'b1;
        end
        if (pop_e) mlevel--;
        if (mst == 0) begin
            mst = (lvl_pre > 0) ? 1 : 0;
        end else if (rdy) begin
            if (mst == NB) mst = (mlevel > 0) ? 1 : 0;
            else mst++;
        end
        mts++;
        @(negedge clock);
        chk("fifo_level", fifo_level, mlevel);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 32'h0, 4'h0, rdy);
    endtask

    task automatic samp(input logic [31:0] d, input logic [3:0] f, input bit rdy);
        step(1'b1, 1'b1, d, f, rdy);
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) idle(1'b1);
        chk("drain_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        enable    = 1'b0;
        tap_valid = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        mlevel = 0;
        mdrop  = 0;
        mst    = 0;
        movf   = 1'b0;
        mseq   = '0;
        mts    = '0;
    endtask

    initial begin
        @(negedge clock);
        do_reset(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", fifo_level, 0);

        // single sample and first-beat latency
        samp(32'hDEADBEEF, 4'b1010, 1'b1);
        chk("lat_not_yet", out_valid, 0);
        idle(1'b1);
        chk("lat_hdr_valid", out_valid, 1);
        chk("lat_hdr_data", out_data, 16'hA000);
        drain();

        // back-pressure in the middle of a record
        samp(32'h12345678, 4'h5, 1'b1);
        idle(1'b1);
        idle(1'b1);
        for (int k = 0; k < 10; k++) begin
            idle(1'b0);
            chk("stall_data", out_data, 16'h5678);
            chk("stall_valid", out_valid, 1);
        end
        drain();

        // overflow: four stored, two dropped
        do_reset(1);
        for (int i = 0; i < 6; i++) samp(32'h1000 + 32'(i), 4'(i), 1'b0);
        chk("ovf_level", fifo_level, 4);
        drain();
        samp(32'hCAFEF00D, 4'h0, 1'b1);
        idle(1'b1);
        chk("ovf_hdr", out_data, 16'h0A04);
        drain();

        // drop counter saturation
        do_reset(1);
        for (int i = 0; i < 24; i++) samp(32'h2000 + 32'(i), 4'h1, 1'b0);
        drain();
        samp(32'h0BAD0BAD, 4'h0, 1'b1);
        idle(1'b1);
        chk("sat_hdr", out_data, 16'h0F04);
        drain();

        // sequence wrap
        do_reset(1);
        for (int i = 0; i < 256; i++) begin
            samp(32'(i) * 32'h00010001, 4'(i), 1'b1);
            for (int k = 0; k < NB - 1; k++) idle(1'b1);
        end
        drain();
        samp(32'h0, 4'h3, 1'b1);
        idle(1'b1);
        chk("wrap_hdr", out_data, 16'h3000);
        drain();

        // push coinciding with last-beat pop at full
        do_reset(1);
        for (int i = 0; i < 4; i++) samp(32'h3000 + 32'(i), 4'h6, 1'b0);
        for (int k = 0; k < NB - 1; k++) idle(1'b1);
        chk("pp_at_last", out_last, 1);
        samp(32'h44445555, 4'h7, 1'b1);
        chk("pp_level", fifo_level, 4);
        drain();

        // reset in the middle of a record
        samp(32'hAAAA5555, 4'hF, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("mid_dlo_valid", out_valid, 1);
        chk("mid_dlo_data", out_data, 16'h5555);
        do_reset(1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        for (int k = 0; k < 3; k++) idle(1'b1);
        samp(32'h01020304, 4'h2, 1'b1);
        idle(1'b1);
        chk("mid_seq0_hdr", out_data, 16'h2000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
